// File: rtl/lfsr_seq_ctrl.sv
// Sequencer around a Galois LFSR: loads a seed, streams handshaked bursts of
// pseudo-random words, and measures the LFSR period on command.
module lfsr_seq_ctrl #(
  parameter int unsigned          BITWIDTH     = 5,
  parameter logic [BITWIDTH-1:0]  TAPS         = 5'b10100,
  parameter logic [BITWIDTH-1:0]  DEFAULT_SEED = 5'b00001,
  parameter int unsigned          CNT_W        = 8
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                seed_load,
  input  logic [BITWIDTH-1:0] seed_in,
  input  logic                start,
  input  logic [CNT_W-1:0]    burst_len,
  input  logic                measure,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [BITWIDTH-1:0] out_data,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    period,
  output logic                period_valid,
  output logic                seed_fixed
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    MEASURE
  } state_e;

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] lfsr_q, lfsr_d;
  logic [BITWIDTH-1:0] snapshot_q, snapshot_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                periodValid_q, periodValid_d;
  logic                seedFixed_q, seedFixed_d;
  logic                done_q, done_d;
  logic [BITWIDTH-1:0] lfsrNext;
  logic                handshake;

  // One Galois step: shift right, fold the taps in when a one falls off the end.
  function automatic logic [BITWIDTH-1:0] lfsrStep(input logic [BITWIDTH-1:0] v);
    if (v[0]) begin
      return (v >> 1) ^ TAPS;
    end
    return v >> 1;
  endfunction

  assign lfsrNext     = lfsrStep(lfsr_q);
  assign handshake    = (state_q == BURST) && out_ready;

  assign out_valid    = (state_q == BURST);
  assign out_data     = lfsr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign period       = period_q;
  assign period_valid = periodValid_q;
  assign seed_fixed   = seedFixed_q;

  // Next-state and datapath decisions for the IDLE/BURST/MEASURE controller.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    snapshot_d    = snapshot_q;
    remaining_d   = remaining_q;
    cnt_d         = cnt_q;
    period_d      = period_q;
    periodValid_d = periodValid_q;
    seedFixed_d   = seedFixed_q;

    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          periodValid_d = 1'b0;
          if (seed_in == '0) begin
            // An all-zero LFSR would lock up, so substitute the default seed.
            lfsr_d      = DEFAULT_SEED;
            seedFixed_d = 1'b1;
          end else begin
            lfsr_d      = seed_in;
            seedFixed_d = 1'b0;
          end
        end else if (measure) begin
          // The snapshot is taken here without stepping; the first MEASURE
          // cycle performs step number one, so cnt counts steps taken and the
          // match cycle reports the true period.
          snapshot_d    = lfsr_q;
          cnt_d         = CNT_ONE;
          periodValid_d = 1'b0;
          state_d       = MEASURE;
        end else if (start && (burst_len != '0)) begin
          remaining_d = burst_len;
          state_d     = BURST;
        end
      end

      BURST: begin
        if (handshake) begin
          lfsr_d      = lfsrNext;
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = IDLE;
          end
        end
      end

      MEASURE: begin
        lfsr_d = lfsrNext;
        if (lfsrNext == snapshot_q) begin
          period_d      = cnt_q;
          periodValid_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          period_d      = CNT_MAX;
          periodValid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  // State and datapath registers; async reset abandons any burst or measurement.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      lfsr_q        <= DEFAULT_SEED;
      snapshot_q    <= '0;
      remaining_q   <= '0;
      cnt_q         <= '0;
      period_q      <= '0;
      periodValid_q <= 1'b0;
      seedFixed_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      snapshot_q    <= snapshot_d;
      remaining_q   <= remaining_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      periodValid_q <= periodValid_d;
      seedFixed_q   <= seedFixed_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with hand-computed expected values.
module tb_lfsr_seq_ctrl;

  logic       clk;
  logic       arst_n;
  logic       seed_load;
  logic [4:0] seed_in;
  logic       start;
  logic [7:0] burst_len;
  logic       measure;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic       busy;
  logic       done;
  logic [7:0] period;
  logic       period_valid;
  logic       seed_fixed;

  int total;
  int bad;

  lfsr_seq_ctrl dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .start        (start),
    .burst_len    (burst_len),
    .measure      (measure),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .period       (period),
    .period_valid (period_valid),
    .seed_fixed   (seed_fixed)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all command inputs in one go.
  task automatic applyStimulus(input logic sl, input logic [4:0] si, input logic ms,
                               input logic st, input logic [7:0] bl, input logic rdy);
    seed_load = sl;
    seed_in   = si;
    measure   = ms;
    start     = st;
    burst_len = bl;
    out_ready = rdy;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] burstExp [5];
    logic [4:0] stallExp [5];
    logic       stallRdy [5];
    int         busyCount;

    total = 0;
    bad   = 0;
    burstExp = '{5'b00001, 5'b10100, 5'b01010, 5'b00101, 5'b10110};
    stallExp = '{5'b00001, 5'b10100, 5'b10100, 5'b10100, 5'b01010};
    stallRdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    arst_n = 1'b0;
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    #12;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_pvalid", period_valid, 0);
    checkOutput("rst_sfixed", seed_fixed, 0);
    checkOutput("rst_data", out_data, 5'b00001);
    arst_n = 1'b1;
    tick();

    $display("[TB] burst of 5 from reset seed");
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b1, 8'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("b5_valid", out_valid, 1);
      checkOutput("b5_busy", busy, 1);
      checkOutput("b5_done", done, 0);
      checkOutput($sformatf("b5_data%0d", i), out_data, burstExp[i]);
      tick();
    end
    checkOutput("b5_end_busy", busy, 0);
    checkOutput("b5_end_done", done, 1);
    checkOutput("b5_end_data", out_data, 5'b01011);
    tick();
    checkOutput("b5_done_clr", done, 0);

    $display("[TB] seed loads");
    applyStimulus(1'b1, 5'b00000, 1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    checkOutput("zseed_data", out_data, 5'b00001);
    checkOutput("zseed_fixed", seed_fixed, 1);
    checkOutput("zseed_busy", busy, 0);
    applyStimulus(1'b1, 5'b10110, 1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    checkOutput("seed_fixed_clr", seed_fixed, 0);
    checkOutput("seed_data", out_data, 5'b10110);
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b1, 8'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    checkOutput("b2_data0", out_data, 5'b10110);
    checkOutput("b2_valid0", out_valid, 1);
    tick();
    checkOutput("b2_data1", out_data, 5'b01011);
    tick();
    checkOutput("b2_done", done, 1);
    checkOutput("b2_busy", busy, 0);

    $display("[TB] period measurement");
    applyStimulus(1'b1, 5'b00001, 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("meas_nvalid", out_valid, 0);
    busyCount = 0;
    while (busy && busyCount < 100) begin
      busyCount++;
      tick();
    end
    checkOutput("meas_cycles", busyCount, 31);
    checkOutput("meas_period", period, 31);
    checkOutput("meas_pvalid", period_valid, 1);
    checkOutput("meas_done", done, 1);
    checkOutput("meas_data", out_data, 5'b00001);
    tick();
    checkOutput("meas_done_clr", done, 0);

    $display("[TB] burst of 3 with stalls");
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b1, 8'd3, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, stallRdy[i]);
      checkOutput($sformatf("st_data%0d", i), out_data, stallExp[i]);
      checkOutput("st_busy", busy, 1);
      checkOutput("st_done", done, 0);
      tick();
    end
    checkOutput("st_end_busy", busy, 0);
    checkOutput("st_end_done", done, 1);
    checkOutput("st_end_data", out_data, 5'b00101);

    $display("[TB] command priority and zero-length start");
    applyStimulus(1'b1, 5'b10011, 1'b1, 1'b1, 8'd4, 1'b1);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    checkOutput("prio_busy", busy, 0);
    checkOutput("prio_data", out_data, 5'b10011);
    checkOutput("prio_pvalid", period_valid, 0);
    tick();
    checkOutput("prio_busy2", busy, 0);
    checkOutput("prio_done", done, 0);
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b1, 8'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    checkOutput("zlen_busy", busy, 0);
    checkOutput("zlen_done", done, 0);
    tick();
    checkOutput("zlen_done2", done, 0);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b1, 8'd10, 1'b1);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    tick();
    checkOutput("mid_busy_pre", busy, 1);
    arst_n = 1'b0;
    #1;
    checkOutput("mid_valid", out_valid, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_data", out_data, 5'b00001);
    arst_n = 1'b1;
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b1, 8'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    checkOutput("post_busy", busy, 1);
    checkOutput("post_data", out_data, 5'b00001);
    tick();
    checkOutput("post_done", done, 1);
    checkOutput("post_data2", out_data, 5'b10100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
